// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - sequence monitor for a wrapping up-counter
// Tracks the expected counter value, flags sticky violations and counts observed wraps.
module counter_checker #(
    parameter int             W     = 4,
    parameter logic [W-1:0]   KMAX  = 4'b1111,
    parameter int             WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     x,
    output logic             wrap_pulse,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic             err,
    output logic [1:0]       state,
    output logic             prop
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        ERR  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     exp_q, exp_d;
    logic             err_d;
    logic             pulse_d;
    logic [WRAPW-1:0] cnt_d;

    function automatic logic [W-1:0] step(input logic [W-1:0] v, input logic e);
        if (!e)
            return v;
        else if (v == KMAX)
            return W'(1);
        else
            return v + W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            exp_q      <= W'(1);
            err        <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            err        <= err_d;
            wrap_pulse <= pulse_d;
            wrap_cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        err_d   = err;
        pulse_d = 1'b0;
        cnt_d   = wrap_cnt;
        case (state_q)
            IDLE: begin
                // First cycle out of reset adopts whatever non-zero value the counter shows.
                if (x != '0) begin
                    exp_d   = step(x, en);
                    state_d = RUN;
                end else begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            RUN: begin
                if (x == exp_q) begin
                    exp_d = step(exp_q, en);
                    if (en && (x == KMAX)) begin
                        pulse_d = 1'b1;
                        if (wrap_cnt != '1)
                            cnt_d = wrap_cnt + WRAPW'(1);
                    end
                end else begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            ERR: begin
            end
            default: begin
                state_d = ERR;
                err_d   = 1'b1;
            end
        endcase
    end

    assign state = state_q;
    assign prop  = !err;

endmodule
